// File: rtl/wh_noc_pkg.sv
// Shared types for the wormhole NoC router: flit type encoding and allocator FSM states.
package wh_noc_pkg;

   localparam int FLIT_TYPE_BITS = 2;

   typedef enum logic [FLIT_TYPE_BITS-1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_e;

   typedef enum logic {
      ALLOC_IDLE   = 1'b0,
      ALLOC_LOCKED = 1'b1
   } alloc_state_e;

   // Callers pass the top FLIT_TYPE_BITS of the flit; flit width is set per instance.
   function automatic flit_type_e get_flit_type(input logic [FLIT_TYPE_BITS-1:0] type_bits);
      return flit_type_e'(type_bits);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr (wrapping) wins.
// Shared by the output allocator and the VC allocator.
module rr_arbiter #(
   parameter int N = 5,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   localparam logic [IW:0] N_W = (IW+1)'(N);

   logic [IW:0] cand;

   // Scan offsets high to low so the smallest offset from ptr is the one left standing.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int off = N - 1; off >= 0; off--) begin
         cand = {1'b0, ptr} + (IW+1)'(off);
         if (cand >= N_W) begin
            cand = cand - N_W;
         end
         if (req[cand[IW-1:0]]) begin
            grant                 = '0;
            grant[cand[IW-1:0]]   = 1'b1;
            grant_idx             = cand[IW-1:0];
            grant_valid           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wormhole_output_allocator.sv
// Per-output wormhole switch allocator: round-robin pick of a head flit, lock until tail.
// Optional stall watchdog enabled by defining WH_ALLOC_WATCHDOG_EN.
module wormhole_output_allocator
   import wh_noc_pkg::*;
#(
   parameter int NUM_REQ        = 5,
   parameter int FLIT_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_in,
   input  logic [NUM_REQ*FLIT_WIDTH-1:0] flit_in,
   input  logic [NUM_REQ-1:0]            valid_in,
   output logic [NUM_REQ-1:0]            ready_out,
   output logic [FLIT_WIDTH-1:0]         flit_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic [NUM_REQ-1:0]            grant_out,
   output logic                          stall_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   alloc_state_e     state_reg, state_next;
   logic [IDX_W-1:0] owner_reg, owner_next;
   logic [NUM_REQ-1:0] owner_oh_reg, owner_oh_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;

   logic [FLIT_WIDTH-1:0] flit_arr [NUM_REQ];
   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    arb_grant;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_valid;
   logic                  locked, active, xfer, owner_last, wd_fire;
   flit_type_e            owner_type;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
         flit_type_e head_type;
         assign flit_arr[gi]  = flit_in[gi*FLIT_WIDTH +: FLIT_WIDTH];
         assign head_type     = get_flit_type(flit_arr[gi][FLIT_WIDTH-1 -: FLIT_TYPE_BITS]);
         assign eligible[gi]  = req_in[gi] & valid_in[gi] &
                                ((head_type == FLIT_HEAD) || (head_type == FLIT_SINGLE));
         assign ready_out[gi] = active & owner_oh_reg[gi] & ready_in;
      end
   endgenerate

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req         (eligible),
      .ptr         (ptr_reg),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // Outputs are gated during reset so a mid-packet reset never moves a flit.
   assign locked     = (state_reg == ALLOC_LOCKED);
   assign active     = locked & ~rst;
   assign flit_out   = flit_arr[owner_reg];
   assign valid_out  = active & valid_in[owner_reg];
   assign xfer       = valid_out & ready_in;
   assign owner_type = get_flit_type(flit_out[FLIT_WIDTH-1 -: FLIT_TYPE_BITS]);
   assign owner_last = (owner_type == FLIT_TAIL) || (owner_type == FLIT_SINGLE);
   assign grant_out  = owner_oh_reg;
   assign stall_err  = wd_fire;

`ifdef WH_ALLOC_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;

   assign wd_fire = active & ~xfer & (wd_cnt_reg == WD_LIMIT);

   always_comb begin
      wd_cnt_next = wd_cnt_reg + WD_W'(1);
      if (!locked || xfer || wd_fire) begin
         wd_cnt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_reg <= '0;
      end else begin
         wd_cnt_reg <= wd_cnt_next;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      owner_oh_next = owner_oh_reg;
      ptr_next      = ptr_reg;
      case (state_reg)
         ALLOC_IDLE: begin
            if (arb_valid) begin
               state_next    = ALLOC_LOCKED;
               owner_next    = arb_idx;
               owner_oh_next = arb_grant;
            end
         end
         ALLOC_LOCKED: begin
            // Bubbles and backpressure hold the lock; only a tail or the watchdog frees it.
            if ((xfer && owner_last) || wd_fire) begin
               state_next    = ALLOC_IDLE;
               owner_oh_next = '0;
               ptr_next      = (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
            end
         end
         default: begin
            state_next    = ALLOC_IDLE;
            owner_oh_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ALLOC_IDLE;
         owner_reg    <= '0;
         owner_oh_reg <= '0;
         ptr_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         owner_oh_reg <= owner_oh_next;
         ptr_reg      <= ptr_next;
      end
   end

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Bench for wormhole_output_allocator: directed vector table, hand sequences, random vs queue model.
// Watchdog expectations follow WH_ALLOC_WATCHDOG_EN.
module tb_wormhole_output_allocator;

   localparam int N  = 5;
   localparam int FW = 32;
   localparam int TO = 8;
   localparam logic [1:0] B = 2'b00, H = 2'b01, T = 2'b10, S = 2'b11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_in = '0, valid_in = '0, ready_out, grant_out;
   logic [N*FW-1:0] flit_in = '0;
   logic [FW-1:0] flit_out;
   logic          valid_out, stall_err;
   logic          ready_in = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wormhole_output_allocator #(.NUM_REQ(N), .FLIT_WIDTH(FW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .flit_in(flit_in), .valid_in(valid_in),
      .ready_out(ready_out), .flit_out(flit_out), .valid_out(valid_out), .ready_in(ready_in),
      .grant_out(grant_out), .stall_err(stall_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic         rst;
      logic [N-1:0] req, vld;
      logic [2*N-1:0] ty;
      logic         rdy;
      logic [N-1:0] eg;
      logic         ev;
      logic [N-1:0] er;
      int           src;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic [N-1:0] rq, input logic [N-1:0] vl,
                              input logic [2*N-1:0] ty, input logic rd, input logic [N-1:0] eg,
                              input logic ev, input logic [N-1:0] er, input int src);
      vec_t x;
      x.rst = r; x.req = rq; x.vld = vl; x.ty = ty; x.rdy = rd;
      x.eg = eg; x.ev = ev; x.er = er; x.src = src;
      return x;
   endfunction

   task automatic do_reset();
      rst = 1'b1; req_in = '0; valid_in = '0; flit_in = '0; ready_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Reference model: per-input flit FIFOs plus owner/pointer bookkeeping.
   logic [FW-1:0] q [N][$];
   int m_owner, m_ptr, m_stall;

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         int c;
         logic [1:0] ty;
         c  = (m_ptr + k) % N;
         ty = flit_in[c*FW + FW - 2 +: 2];
         if (req_in[c] && valid_in[c] && (ty == H || ty == S)) return c;
      end
      return -1;
   endfunction

   function automatic int remaining();
      int s = 0;
      for (int i = 0; i < N; i++) s += q[i].size();
      return s;
   endfunction

   initial begin
      logic [N-1:0] one;
      int seq;
      one = 1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_grant", grant_out, 0);
      chk("reset_valid_out", valid_out, 0);
      chk("reset_ready_out", ready_out, 0);
      chk("reset_stall_err", stall_err, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors: single packet, non-head in IDLE, contention, backpressure, mid-packet reset
      tbl.push_back(v(0, 5'b00100, 5'b00100, {B,B,H,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00100, 5'b00100, {B,B,H,B,B}, 1, 5'b00100, 1, 5'b00100, 2));
      tbl.push_back(v(0, 5'b00100, 5'b00100, {B,B,B,B,B}, 1, 5'b00100, 1, 5'b00100, 2));
      tbl.push_back(v(0, 5'b00100, 5'b00100, {B,B,T,B,B}, 1, 5'b00100, 1, 5'b00100, 2));
      tbl.push_back(v(0, 5'b00000, 5'b00000, {B,B,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00010, 5'b00010, {B,B,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00010, 5'b00010, {B,B,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(1, 5'b00010, 5'b00010, {B,B,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b01001, 5'b01001, {B,H,B,B,H}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b01001, 5'b01001, {B,H,B,B,H}, 1, 5'b00001, 1, 5'b00001, 0));
      tbl.push_back(v(0, 5'b01001, 5'b01001, {B,H,B,B,T}, 1, 5'b00001, 1, 5'b00001, 0));
      tbl.push_back(v(0, 5'b01000, 5'b01000, {B,H,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b01000, 5'b01000, {B,H,B,B,B}, 1, 5'b01000, 1, 5'b01000, 3));
      tbl.push_back(v(0, 5'b01000, 5'b01000, {B,T,B,B,B}, 1, 5'b01000, 1, 5'b01000, 3));
      tbl.push_back(v(0, 5'b00000, 5'b00000, {B,B,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00100, 5'b00100, {B,B,H,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00100, 5'b00100, {B,B,H,B,B}, 1, 5'b00100, 1, 5'b00100, 2));
      tbl.push_back(v(0, 5'b00101, 5'b00101, {B,B,B,B,H}, 0, 5'b00100, 1, 5'b00000, 2));
      tbl.push_back(v(0, 5'b00101, 5'b00101, {B,B,B,B,H}, 0, 5'b00100, 1, 5'b00000, 2));
      tbl.push_back(v(0, 5'b00101, 5'b00001, {B,B,B,B,H}, 0, 5'b00100, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00101, 5'b00001, {B,B,B,B,H}, 0, 5'b00100, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00101, 5'b00001, {B,B,B,B,H}, 1, 5'b00100, 0, 5'b00100, -1));
      tbl.push_back(v(0, 5'b00101, 5'b00101, {B,B,B,B,H}, 0, 5'b00100, 1, 5'b00000, 2));
      tbl.push_back(v(0, 5'b00101, 5'b00101, {B,B,B,B,H}, 1, 5'b00100, 1, 5'b00100, 2));
      tbl.push_back(v(0, 5'b00101, 5'b00101, {B,B,T,B,H}, 1, 5'b00100, 1, 5'b00100, 2));
      tbl.push_back(v(0, 5'b00001, 5'b00001, {B,B,B,B,H}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00001, 5'b00001, {B,B,B,B,H}, 1, 5'b00001, 1, 5'b00001, 0));
      tbl.push_back(v(0, 5'b00001, 5'b00001, {B,B,B,B,T}, 1, 5'b00001, 1, 5'b00001, 0));
      tbl.push_back(v(0, 5'b00000, 5'b00000, {B,B,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00100, 5'b00100, {B,B,H,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b00100, 5'b00100, {B,B,H,B,B}, 1, 5'b00100, 1, 5'b00100, 2));
      tbl.push_back(v(1, 5'b00100, 5'b00100, {B,B,B,B,B}, 1, 5'b00100, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b01101, 5'b01101, {B,S,B,B,S}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b01101, 5'b01101, {B,S,B,B,S}, 1, 5'b00001, 1, 5'b00001, 0));
      tbl.push_back(v(0, 5'b01100, 5'b01100, {B,S,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));
      tbl.push_back(v(0, 5'b01100, 5'b01100, {B,S,B,B,B}, 1, 5'b01000, 1, 5'b01000, 3));
      tbl.push_back(v(0, 5'b00000, 5'b00000, {B,B,B,B,B}, 1, 5'b00000, 0, 5'b00000, -1));

      for (int k = 0; k < tbl.size(); k++) begin
         rst = tbl[k].rst; req_in = tbl[k].req; valid_in = tbl[k].vld; ready_in = tbl[k].rdy;
         for (int i = 0; i < N; i++)
            flit_in[i*FW +: FW] = {tbl[k].ty[2*i +: 2], 30'(i*1000 + k)};
         @(negedge clk);
         chk($sformatf("vec%0d_grant", k), grant_out, tbl[k].eg);
         chk($sformatf("vec%0d_valid_out", k), valid_out, tbl[k].ev);
         chk($sformatf("vec%0d_ready_out", k), ready_out, tbl[k].er);
         chk($sformatf("vec%0d_stall_err", k), stall_err, 0);
         if (tbl[k].ev)
            chk($sformatf("vec%0d_flit", k), flit_out,
                {tbl[k].ty[2*tbl[k].src +: 2], 30'(tbl[k].src*1000 + k)});
         @(posedge clk);
         #1;
      end

      // Fairness: in1..in4 stream SINGLE flits; grants rotate 1,2,3,4 with an idle cycle between.
      do_reset();
      for (int c = 0; c < 16; c++) begin
         req_in = 5'b11110; valid_in = 5'b11110; ready_in = 1'b1;
         for (int i = 0; i < N; i++) flit_in[i*FW +: FW] = {S, 30'(i)};
         @(negedge clk);
         chk($sformatf("fair%0d_grant", c), grant_out, (c % 2 == 0) ? 0 : one << (1 + (c / 2) % 4));
         chk($sformatf("fair%0d_valid_out", c), valid_out, c % 2);
         @(posedge clk);
         #1;
      end

      // Watchdog: in3 sends HEAD then goes silent while in1 waits with a HEAD.
      do_reset();
      for (int s = -1; s <= 12; s++) begin
         logic [N-1:0] eg;
         logic         es;
         ready_in = 1'b1;
         for (int i = 0; i < N; i++) flit_in[i*FW +: FW] = {H, 30'(i)};
         if (s <= 0) begin req_in = 5'b01000; valid_in = 5'b01000; end
         else        begin req_in = 5'b00010; valid_in = 5'b00010; end
         es = 1'b0;
         if (s < 0) eg = 5'b00000;
         else       eg = 5'b01000;
`ifdef WH_ALLOC_WATCHDOG_EN
         es = (s == TO);
         if (s == TO + 1) eg = 5'b00000;
         if (s >= TO + 2) eg = 5'b00010;
`endif
         @(negedge clk);
         chk($sformatf("wdog%0d_grant", s), grant_out, eg);
         chk($sformatf("wdog%0d_stall_err", s), stall_err, es);
         @(posedge clk);
         #1;
      end

      // Random traffic against the queue model.
      do_reset();
      seq = 0;
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         for (int p = 0; p < 10; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
               logic [1:0] ty;
               ty = (len == 1) ? S : (j == 0) ? H : (j == len - 1) ? T : B;
               q[i].push_back({ty, 30'((i << 20) | seq)});
               seq++;
            end
         end
      end
      m_owner = -1; m_ptr = 0; m_stall = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic [N-1:0] eg, er;
         logic ev, xfer, es;
         int o;
         if (m_owner < 0 && remaining() == 0) break;
         for (int i = 0; i < N; i++) begin
            logic has;
            has = (q[i].size() > 0);
            valid_in[i] = has && ($urandom % 8 != 0);
            req_in[i]   = has ? ($urandom % 6 != 0) : 1'($urandom % 2);
            flit_in[i*FW +: FW] = has ? q[i][0] : $urandom;
         end
         ready_in = ($urandom % 4 != 0);
         o  = m_owner;
         eg = (o < 0) ? '0 : one << o;
         ev = (o >= 0) && valid_in[o];
         er = (o >= 0 && ready_in) ? one << o : '0;
         xfer = ev && ready_in;
         es = 1'b0;
`ifdef WH_ALLOC_WATCHDOG_EN
         es = (o >= 0) && !xfer && (m_stall == TO - 1);
`endif
         @(negedge clk);
         chk($sformatf("rnd%0d_grant", cyc), grant_out, eg);
         chk($sformatf("rnd%0d_valid_out", cyc), valid_out, ev);
         chk($sformatf("rnd%0d_ready_out", cyc), ready_out, er);
         chk($sformatf("rnd%0d_stall_err", cyc), stall_err, es);
         if (ev) chk($sformatf("rnd%0d_flit", cyc), flit_out, q[o][0]);
         @(posedge clk);
         if (o < 0) begin
            m_owner = pick();
            m_stall = 0;
         end else if (xfer) begin
            logic [FW-1:0] f;
            f = q[o].pop_front();
            m_stall = 0;
            if (f[FW-1]) begin m_owner = -1; m_ptr = (o + 1) % N; end
         end else if (es) begin
            // Upstream flushes the orphaned packet remainder after a watchdog release.
            while (q[o].size() > 0 && !(q[o][0][FW-1:FW-2] == H || q[o][0][FW-1:FW-2] == S))
               void'(q[o].pop_front());
            m_owner = -1; m_ptr = (o + 1) % N; m_stall = 0;
         end else begin
            m_stall++;
         end
         #1;
      end
      chk("rnd_drained_flits", remaining(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
